// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, control-bundle types and helpers for the MIPS pipeline control unit.
// Optional immediate ALU ops are enabled by PIPE_CTRL_IMM_EN (see pipe_ctrl_decode).
package pipe_ctrl_pkg;

   localparam int XLEN    = 32;
   localparam int ALUOP_W = 5;
   localparam int CNT_W   = 16;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [ALUOP_W-1:0] ALU_ADD = 5'b00001;
   localparam logic [ALUOP_W-1:0] ALU_SUB = 5'b00010;
   localparam logic [ALUOP_W-1:0] ALU_AND = 5'b00100;
   localparam logic [ALUOP_W-1:0] ALU_SLT = 5'b01000;
   localparam logic [ALUOP_W-1:0] ALU_OR  = 5'b10000;
   localparam logic [ALUOP_W-1:0] ALU_NOP = 5'b11111;

   typedef struct packed {
      logic               reg_dst;
      logic               alu_src;
      logic [ALUOP_W-1:0] alu_op;
   } ex_ctrl_t;

   typedef struct packed {
      logic bne;
      logic beq;
      logic mem_read;
      logic mem_write;
   } m_ctrl_t;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } wb_ctrl_t;

   typedef enum logic [1:0] {
      PC_SEL_PC4    = 2'd0,
      PC_SEL_BRANCH = 2'd1,
      PC_SEL_JUMP   = 2'd2
   } pc_sel_e;

   // Performance counters stick at all ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      logic [CNT_W-1:0] result;
      if (&value) begin
         result = value;
      end else begin
         result = value + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      return result;
   endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Datapath <-> control-unit signal bundle; the datapath is the master, the control unit the slave.
interface pipe_ctrl_unit_if;
   import pipe_ctrl_pkg::*;

   logic [XLEN-1:0]      id_inst;
   logic                 id_valid;
   logic [XLEN-1:0]      id_pc4;
   logic                 ex_zero;

   logic [2+ALUOP_W-1:0] ex_ctrl;
   logic [3:0]           ex_m_ctrl;
   logic [1:0]           ex_wb_ctrl;
   logic [1:0]           mem_m_ctrl;
   logic [1:0]           mem_wb_ctrl;
   logic [1:0]           wb_wb_ctrl;
   logic                 pc_write;
   logic                 ifid_write;
   logic                 ifid_flush;
   logic [1:0]           pc_sel;
   logic [XLEN-1:0]      jump_target;
   logic                 illegal;
   logic [CNT_W-1:0]     stall_cnt;
   logic [CNT_W-1:0]     flush_cnt;

   modport master (
      output id_inst, id_valid, id_pc4, ex_zero,
      input  ex_ctrl, ex_m_ctrl, ex_wb_ctrl, mem_m_ctrl, mem_wb_ctrl, wb_wb_ctrl,
      input  pc_write, ifid_write, ifid_flush, pc_sel, jump_target, illegal,
      input  stall_cnt, flush_cnt
   );

   modport slave (
      input  id_inst, id_valid, id_pc4, ex_zero,
      output ex_ctrl, ex_m_ctrl, ex_wb_ctrl, mem_m_ctrl, mem_wb_ctrl, wb_wb_ctrl,
      output pc_write, ifid_write, ifid_flush, pc_sel, jump_target, illegal,
      output stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipe_ctrl_decode.sv
// Pure combinational decoder for the ID-stage instruction.
// PIPE_CTRL_IMM_EN enables ADDI/ANDI/ORI/SLTI; otherwise those opcodes decode as illegal.
module pipe_ctrl_decode
   import pipe_ctrl_pkg::*;
(
   input  logic [5:0] i_op,
   input  logic [5:0] i_funct,
   input  logic       i_valid,
   output ex_ctrl_t   o_ex,
   output m_ctrl_t    o_m,
   output wb_ctrl_t   o_wb,
   output logic       o_illegal,
   output logic       o_uses_rs,
   output logic       o_uses_rt,
   output logic       o_is_jump
);

`ifdef PIPE_CTRL_IMM_EN
   localparam bit IMM_EN = 1'b1;
`else
   localparam bit IMM_EN = 1'b0;
`endif

   ex_ctrl_t w_ex;
   m_ctrl_t  w_m;
   wb_ctrl_t w_wb;
   logic     w_bad;
   logic     w_rt_use;
   logic     w_jump;

   // Raw opcode/funct decode, before bubble and illegal masking.
   always_comb begin
      w_ex     = '0;
      w_m      = '0;
      w_wb     = '0;
      w_bad    = 1'b0;
      w_rt_use = 1'b0;
      w_jump   = 1'b0;
      case (i_op)
         OP_RTYPE: begin
            w_ex.reg_dst    = 1'b1;
            w_wb.reg_write  = 1'b1;
            w_rt_use        = 1'b1;
            case (i_funct)
               FN_ADD:  w_ex.alu_op = ALU_ADD;
               FN_SUB:  w_ex.alu_op = ALU_SUB;
               FN_AND:  w_ex.alu_op = ALU_AND;
               FN_SLT:  w_ex.alu_op = ALU_SLT;
               FN_OR:   w_ex.alu_op = ALU_OR;
               default: w_bad       = 1'b1;
            endcase
         end
         OP_LW: begin
            w_ex.alu_src    = 1'b1;
            w_ex.alu_op     = ALU_ADD;
            w_wb.reg_write  = 1'b1;
            w_wb.mem_to_reg = 1'b1;
            w_m.mem_read    = 1'b1;
         end
         OP_SW: begin
            w_ex.alu_src    = 1'b1;
            w_ex.alu_op     = ALU_ADD;
            w_m.mem_write   = 1'b1;
            w_rt_use        = 1'b1;
         end
         OP_BEQ: begin
            w_m.beq         = 1'b1;
            w_ex.alu_op     = ALU_SUB;
            w_rt_use        = 1'b1;
         end
         OP_BNE: begin
            w_m.bne         = 1'b1;
            w_ex.alu_op     = ALU_SUB;
            w_rt_use        = 1'b1;
         end
         OP_J: begin
            w_jump          = 1'b1;
         end
         OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
            if (IMM_EN) begin
               w_ex.alu_src   = 1'b1;
               w_wb.reg_write = 1'b1;
               case (i_op)
                  OP_ADDI: w_ex.alu_op = ALU_ADD;
                  OP_ANDI: w_ex.alu_op = ALU_AND;
                  OP_ORI:  w_ex.alu_op = ALU_OR;
                  default: w_ex.alu_op = ALU_SLT;
               endcase
            end else begin
               w_bad = 1'b1;
            end
         end
         default: begin
            w_bad = 1'b1;
         end
      endcase
   end

   // Bubbles become all-zero NOPs; undecoded instructions keep only ALU_NOP.
   always_comb begin
      o_ex      = '0;
      o_m       = '0;
      o_wb      = '0;
      o_illegal = 1'b0;
      if (!i_valid) begin
         o_ex = '0;
      end else if (w_bad) begin
         o_ex.alu_op = ALU_NOP;
         o_illegal   = 1'b1;
      end else begin
         o_ex = w_ex;
         o_m  = w_m;
         o_wb = w_wb;
      end
   end

   // A jump's rs field is part of its target, so it never consumes a register.
   assign o_uses_rs = i_valid & ~w_jump;
   assign o_uses_rt = i_valid & w_rt_use;
   assign o_is_jump = i_valid & w_jump;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: ID/EX, EX/MEM, MEM/WB control registers, hazard/redirect logic, counters.
// Optional immediate ALU ops via PIPE_CTRL_IMM_EN (handled inside pipe_ctrl_decode).
module pipe_ctrl_unit
   import pipe_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   pipe_ctrl_unit_if.slave  bus
);

   ex_ctrl_t         w_dec_ex;
   m_ctrl_t          w_dec_m;
   wb_ctrl_t         w_dec_wb;
   logic             w_illegal;
   logic             w_uses_rs;
   logic             w_uses_rt;
   logic             w_is_jump;

   logic [4:0]       w_id_rs;
   logic [4:0]       w_id_rt;
   logic             w_taken;
   logic             w_stall;
   logic             w_jump;
   logic             w_bubble;
   logic             w_pc_write;
   logic             w_ifid_write;
   logic             w_ifid_flush;
   pc_sel_e          w_pc_sel;

   ex_ctrl_t         r_ex_ctrl;
   m_ctrl_t          r_ex_m;
   wb_ctrl_t         r_ex_wb;
   logic [4:0]       r_ex_rt;
   logic [1:0]       r_mem_m;
   wb_ctrl_t         r_mem_wb;
   wb_ctrl_t         r_wb_wb;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   pipe_ctrl_decode u_decode (
      .i_op      (bus.id_inst[31:26]),
      .i_funct   (bus.id_inst[5:0]),
      .i_valid   (bus.id_valid),
      .o_ex      (w_dec_ex),
      .o_m       (w_dec_m),
      .o_wb      (w_dec_wb),
      .o_illegal (w_illegal),
      .o_uses_rs (w_uses_rs),
      .o_uses_rt (w_uses_rt),
      .o_is_jump (w_is_jump)
   );

   assign w_id_rs = bus.id_inst[25:21];
   assign w_id_rt = bus.id_inst[20:16];

   // Hazard and redirect detection; a taken branch makes everything younger wrong-path.
   always_comb begin
      w_taken  = (r_ex_m.beq & bus.ex_zero) | (r_ex_m.bne & ~bus.ex_zero);
      w_stall  = ~w_taken & r_ex_m.mem_read & (r_ex_rt != 5'd0)
               & ((w_uses_rs & (r_ex_rt == w_id_rs)) | (w_uses_rt & (r_ex_rt == w_id_rt)));
      w_jump   = ~w_taken & w_is_jump;
      w_bubble = w_taken | w_stall;
   end

   // PC / IF-ID steering, in priority order branch > stall > jump.
   always_comb begin
      w_pc_write   = 1'b1;
      w_ifid_write = 1'b1;
      w_ifid_flush = 1'b0;
      w_pc_sel     = PC_SEL_PC4;
      if (w_taken) begin
         w_ifid_flush = 1'b1;
         w_pc_sel     = PC_SEL_BRANCH;
      end else if (w_stall) begin
         w_pc_write   = 1'b0;
         w_ifid_write = 1'b0;
      end else if (w_jump) begin
         w_ifid_flush = 1'b1;
         w_pc_sel     = PC_SEL_JUMP;
      end else begin
         w_pc_sel     = PC_SEL_PC4;
      end
   end

   // Stage registers: ID/EX takes decode or a bubble, later stages always advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_ctrl <= '0;
         r_ex_m    <= '0;
         r_ex_wb   <= '0;
         r_ex_rt   <= 5'd0;
         r_mem_m   <= 2'b00;
         r_mem_wb  <= '0;
         r_wb_wb   <= '0;
      end else begin
         if (w_bubble) begin
            r_ex_ctrl <= '0;
            r_ex_m    <= '0;
            r_ex_wb   <= '0;
            r_ex_rt   <= 5'd0;
         end else begin
            r_ex_ctrl <= w_dec_ex;
            r_ex_m    <= w_dec_m;
            r_ex_wb   <= w_dec_wb;
            r_ex_rt   <= w_id_rt;
         end
         r_mem_m  <= {r_ex_m.mem_read, r_ex_m.mem_write};
         r_mem_wb <= r_ex_wb;
         r_wb_wb  <= r_mem_wb;
      end
   end

   // Saturating stall and flush event counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
         end else begin
            r_stall_cnt <= r_stall_cnt;
         end
         if (w_taken | w_jump) begin
            r_flush_cnt <= sat_inc(r_flush_cnt);
         end else begin
            r_flush_cnt <= r_flush_cnt;
         end
      end
   end

   assign bus.ex_ctrl     = r_ex_ctrl;
   assign bus.ex_m_ctrl   = r_ex_m;
   assign bus.ex_wb_ctrl  = r_ex_wb;
   assign bus.mem_m_ctrl  = r_mem_m;
   assign bus.mem_wb_ctrl = r_mem_wb;
   assign bus.wb_wb_ctrl  = r_wb_wb;
   assign bus.pc_write    = w_pc_write;
   assign bus.ifid_write  = w_ifid_write;
   assign bus.ifid_flush  = w_ifid_flush;
   assign bus.pc_sel      = w_pc_sel;
   assign bus.jump_target = {bus.id_pc4[31:28], bus.id_inst[25:0], 2'b00};
   assign bus.illegal     = w_illegal;
   assign bus.stall_cnt   = r_stall_cnt;
   assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: an instruction-level pipeline model pushes expected
// outputs per cycle; an independent monitor pops and compares them against the DUT.
module tb_pipe_ctrl_unit;

`ifdef PIPE_CTRL_IMM_EN
   localparam bit IMM = 1'b1;
`else
   localparam bit IMM = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pipe_ctrl_unit_if bus();
   pipe_ctrl_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct packed {
      bit regdst, alusrc;
      bit [4:0] aluop;
      bit bne, beq, mr, mw, rw, m2r;
      bit [4:0] rt;
   } slot_t;

   typedef struct {
      logic [6:0]  exc;
      logic [3:0]  exm;
      logic [1:0]  exwb, memm, memwb, wbwb, psel;
      logic        pcw, ifw, flush, ill;
      logic [31:0] jt;
      int          sc, fc;
   } exp_t;

   slot_t m_ex, m_mem, m_wb;
   int    m_sc, m_fc;
   exp_t  q[$];
   int    total = 0;
   int    bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction semantics straight from the opcode/funct table.
   function automatic void ref_decode(input logic [31:0] ins, input bit v, output slot_t s,
                                      output bit ill, output bit rt_use, output bit is_j);
      int op, fn;
      op = int'(ins[31:26]);
      fn = int'(ins[5:0]);
      s = '0; ill = 0; rt_use = 0; is_j = 0;
      if (v) begin
         if (op == 0) begin
            rt_use = 1;
            case (fn)
               32: s.aluop = 5'd1;
               34: s.aluop = 5'd2;
               36: s.aluop = 5'd4;
               42: s.aluop = 5'd8;
               37: s.aluop = 5'd16;
               default: ill = 1;
            endcase
            s.regdst = 1; s.rw = 1;
         end else if (op == 35) begin
            s.alusrc = 1; s.aluop = 5'd1; s.rw = 1; s.m2r = 1; s.mr = 1;
         end else if (op == 43) begin
            s.alusrc = 1; s.aluop = 5'd1; s.mw = 1; rt_use = 1;
         end else if (op == 4 || op == 5) begin
            s.aluop = 5'd2; s.beq = (op == 4); s.bne = (op == 5); rt_use = 1;
         end else if (op == 2) begin
            is_j = 1;
         end else if (IMM && (op == 8 || op == 12 || op == 13 || op == 10)) begin
            s.alusrc = 1; s.rw = 1;
            s.aluop = (op == 8) ? 5'd1 : (op == 12) ? 5'd4 : (op == 13) ? 5'd16 : 5'd8;
         end else begin
            ill = 1;
         end
         if (ill) begin
            s = '0;
            s.aluop = 5'b11111;
         end
      end
   endfunction

   // Drive one ID-stage cycle, push the expected observation, then advance the model.
   task automatic step(input logic [31:0] ins, input bit v, input logic [31:0] pc4, input bit z);
      slot_t d;
      bit ill, rtu, isj, taken, stall, jmp;
      exp_t e;
      @(negedge clk);
      bus.id_inst = ins; bus.id_valid = v; bus.id_pc4 = pc4; bus.ex_zero = z;
      ref_decode(ins, v, d, ill, rtu, isj);
      taken = (m_ex.beq && z) || (m_ex.bne && !z);
      stall = !taken && m_ex.mr && m_ex.rt != 5'd0 && v && !isj &&
              (m_ex.rt == ins[25:21] || (rtu && m_ex.rt == ins[20:16]));
      jmp   = !taken && isj;
      e.exc   = {m_ex.regdst, m_ex.alusrc, m_ex.aluop};
      e.exm   = {m_ex.bne, m_ex.beq, m_ex.mr, m_ex.mw};
      e.exwb  = {m_ex.rw, m_ex.m2r};
      e.memm  = {m_mem.mr, m_mem.mw};
      e.memwb = {m_mem.rw, m_mem.m2r};
      e.wbwb  = {m_wb.rw, m_wb.m2r};
      e.pcw   = !stall;
      e.ifw   = !stall;
      e.flush = taken || jmp;
      e.psel  = taken ? 2'd1 : (jmp ? 2'd2 : 2'd0);
      e.jt    = {pc4[31:28], ins[25:0], 2'b00};
      e.ill   = ill;
      e.sc    = m_sc;
      e.fc    = m_fc;
      q.push_back(e);
      m_wb  = m_mem;
      m_mem = m_ex;
      if (taken || stall) begin
         m_ex = '0;
      end else begin
         m_ex = d;
         m_ex.rt = ins[20:16];
      end
      if (stall && m_sc < 65535) m_sc++;
      if ((taken || jmp) && m_fc < 65535) m_fc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #3;
      bus.id_valid = 1'b0; bus.id_inst = 32'd0; bus.id_pc4 = 32'd0; bus.ex_zero = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_ex_ctrl", bus.ex_ctrl, 0);
      chk("rst_ex_m_ctrl", bus.ex_m_ctrl, 0);
      chk("rst_ex_wb_ctrl", bus.ex_wb_ctrl, 0);
      chk("rst_mem_m_ctrl", bus.mem_m_ctrl, 0);
      chk("rst_mem_wb_ctrl", bus.mem_wb_ctrl, 0);
      chk("rst_wb_wb_ctrl", bus.wb_wb_ctrl, 0);
      chk("rst_stall_cnt", bus.stall_cnt, 0);
      chk("rst_flush_cnt", bus.flush_cnt, 0);
      m_ex = '0; m_mem = '0; m_wb = '0; m_sc = 0; m_fc = 0;
      repeat (2) @(negedge clk);
      #3 rst_n = 1'b1;
   endtask

   function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
      return {6'd0, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [4:0] rs, rt, rd;
      logic [5:0] fn, iop;
      int k;
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 31));
      k  = $urandom_range(0, 11);
      case ($urandom_range(0, 5))
         0: fn = 6'd32;
         1: fn = 6'd34;
         2: fn = 6'd36;
         3: fn = 6'd37;
         4: fn = 6'd42;
         default: fn = 6'($urandom);
      endcase
      case ($urandom_range(0, 3))
         0: iop = 6'd8;
         1: iop = 6'd12;
         2: iop = 6'd13;
         default: iop = 6'd10;
      endcase
      case (k)
         0, 1, 2, 3, 4: return r_ins(rs, rt, rd, fn);
         5:  return i_ins(6'd35, rs, rt, 16'($urandom));
         6:  return i_ins(6'd43, rs, rt, 16'($urandom));
         7:  return i_ins(6'd4, rs, rt, 16'($urandom));
         8:  return i_ins(6'd5, rs, rt, 16'($urandom));
         9:  return {6'd2, 26'($urandom)};
         10: return i_ins(iop, rs, rt, 16'($urandom));
         default: return 32'($urandom);
      endcase
   endfunction

   // Monitor: compares every queued expectation against the DUT mid-cycle.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("ex_ctrl", bus.ex_ctrl, e.exc);
            chk("ex_m_ctrl", bus.ex_m_ctrl, e.exm);
            chk("ex_wb_ctrl", bus.ex_wb_ctrl, e.exwb);
            chk("mem_m_ctrl", bus.mem_m_ctrl, e.memm);
            chk("mem_wb_ctrl", bus.mem_wb_ctrl, e.memwb);
            chk("wb_wb_ctrl", bus.wb_wb_ctrl, e.wbwb);
            chk("pc_write", bus.pc_write, e.pcw);
            chk("ifid_write", bus.ifid_write, e.ifw);
            chk("ifid_flush", bus.ifid_flush, e.flush);
            chk("pc_sel", bus.pc_sel, e.psel);
            chk("jump_target", bus.jump_target, e.jt);
            chk("illegal", bus.illegal, e.ill);
            chk("stall_cnt", bus.stall_cnt, e.sc);
            chk("flush_cnt", bus.flush_cnt, e.fc);
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      rst_n = 1'b0;
      bus.id_inst = 32'd0; bus.id_valid = 1'b0; bus.id_pc4 = 32'd0; bus.ex_zero = 1'b0;
      m_ex = '0; m_mem = '0; m_wb = '0; m_sc = 0; m_fc = 0;
      do_reset();

      // ADD then LW, then a dependent ADD that must stall exactly once.
      step(r_ins(5'd1, 5'd2, 5'd3, 6'd32), 1, 32'd0, 0);
      step(i_ins(6'd35, 5'd1, 5'd2, 16'd0), 1, 32'd0, 0);
      step(r_ins(5'd2, 5'd4, 5'd3, 6'd32), 1, 32'd0, 0);
      #2 chk("lu_pc_write", bus.pc_write, 0);
      chk("lu_ifid_write", bus.ifid_write, 0);
      step(r_ins(5'd2, 5'd4, 5'd3, 6'd32), 1, 32'd0, 0);
      step(i_ins(6'd35, 5'd1, 5'd0, 16'd0), 1, 32'd0, 0);
      step(r_ins(5'd0, 5'd4, 5'd3, 6'd32), 1, 32'd0, 0);
      #2 chk("lu_rt0_no_stall", bus.pc_write, 1);
      step(32'd0, 0, 32'd0, 0);
      step(32'd0, 0, 32'd0, 0);
      #2 chk("lw_wb_wb_ctrl", bus.wb_wb_ctrl, 2'b11);
      chk("stall_cnt_one", bus.stall_cnt, 1);

      // Taken BEQ wins over a J in ID; BNE with zero=1 is not taken.
      step(i_ins(6'd4, 5'd1, 5'd1, 16'd0), 1, 32'd0, 0);
      step({6'd2, 26'h10}, 1, 32'h4000_0004, 1);
      #2 chk("beq_pc_sel", bus.pc_sel, 1);
      chk("beq_flush", bus.ifid_flush, 1);
      step(32'd0, 0, 32'd0, 0);
      #2 chk("flush_cnt_one", bus.flush_cnt, 1);
      chk("beq_ex_bubble", bus.ex_ctrl, 0);
      step(i_ins(6'd5, 5'd1, 5'd1, 16'd0), 1, 32'd0, 0);
      step(32'd0, 0, 32'd0, 1);
      #2 chk("bne_z1_pc_sel", bus.pc_sel, 0);

      // Jump target and single bubble.
      step({6'd2, 26'h10}, 1, 32'h4000_0004, 0);
      #2 chk("j_target", bus.jump_target, 32'h4000_0040);
      chk("j_pc_sel", bus.pc_sel, 2);
      step(32'd0, 0, 32'd0, 0);
      #2 chk("j_ex_ctrl_nop", bus.ex_ctrl, 0);
      chk("flush_cnt_two", bus.flush_cnt, 2);

      // Undecoded funct, then ADDI (legal only with the immediate option).
      step(r_ins(5'd1, 5'd2, 5'd3, 6'd7), 1, 32'd0, 0);
      #2 chk("ill_flag", bus.illegal, 1);
      step(i_ins(6'd8, 5'd1, 5'd2, 16'd5), 1, 32'd0, 0);
      #2 chk("ill_ex_ctrl", bus.ex_ctrl, 7'b0011111);
      chk("ill_regwrite", bus.ex_wb_ctrl, 2'b00);
      chk("addi_illegal", bus.illegal, IMM ? 1'b0 : 1'b1);
      step(32'd0, 0, 32'd0, 0);
      #2 chk("addi_ex_ctrl", bus.ex_ctrl, IMM ? 7'b0100001 : 7'b0011111);

      // Random traffic with a mid-stream reset.
      repeat (300) step(rand_inst(), $urandom_range(0, 9) != 0, 32'($urandom), 1'($urandom));
      do_reset();
      repeat (200) step(rand_inst(), $urandom_range(0, 9) != 0, 32'($urandom), 1'($urandom));

      repeat (2) @(negedge clk);
      #4 chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Registered control unit for the 5-stage MIPS pipeline. Decodes the ID-stage instruction and carries the EX/M/WB control bundles through the ID/EX, EX/MEM and MEM/WB stage registers. Detects load-use hazards, resolves branches in EX and jumps in ID, and drives PC select, stall and flush. Sits between the IF/ID register and the datapath stage registers.

Parameters:
XLEN, 32, instruction/PC width (fixed opcode/funct field positions; must be 32)
ALUOP_W, 5, one-hot ALU op width; ALU_NOP = all ones
CNT_W, 16, width of the saturating stall/flush performance counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_inst  in  XLEN  instruction in ID (IF/ID output)
id_valid  in  1  id_inst is a real instruction (0 = bubble)
id_pc4  in  XLEN  PC+4 of the ID instruction
ex_zero  in  1  ALU zero flag of the instruction in EX
ex_ctrl  out  2+ALUOP_W  ID/EX register: {RegDst, ALUsrc, ALUop}
ex_m_ctrl  out  4  ID/EX register: {BNE, BEQ, MemRead, MemWrite}
ex_wb_ctrl  out  2  ID/EX register: {RegWrite, MemToReg}
mem_m_ctrl  out  2  EX/MEM register: {MemRead, MemWrite}
mem_wb_ctrl  out  2  EX/MEM register: WB bundle
wb_wb_ctrl  out  2  MEM/WB register: WB bundle
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  zero IF/ID on the next edge
pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = jump target
jump_target  out  XLEN  {id_pc4[31:28], id_inst[25:0], 2'b00}
illegal  out  1  combinational: ID instruction has an undecoded opcode or funct
stall_cnt  out  CNT_W  count of load-use stall cycles, saturating
flush_cnt  out  CNT_W  count of taken branches plus jumps, saturating

Behaviour:
- Reset (async, rst_n=0): all stage-register outputs 0; counters 0.
- Decode (combinational on id_inst):
  - R-type funct: ADD 00001, SUB 00010, AND 00100, SLT 01000, OR 10000. Sets RegDst=1, RegWrite=1.
  - LW: ALUsrc, ADD, RegWrite, MemToReg, MemRead.
  - SW: ALUsrc, ADD, MemWrite.
  - BEQ: BEQ bit and ALUop SUB. BNE: BNE bit and ALUop SUB.
  - J: no stage control.
  - Undecoded opcode or R-funct: all control bits 0, ALUop=ALU_NOP, illegal=1 when id_valid.
  - id_valid=0: decode forced to all-zero NOP, illegal=0.
- Stage registers advance every clock: ID/EX <- decode or bubble; EX/MEM <- ID/EX; MEM/WB <- EX/MEM. No backpressure on EX and later stages.
- Internal ID/EX register also holds ex_rt = id_inst[20:16].
- Load-use stall:
  - Condition: ex_m_ctrl.MemRead=1, ex_rt!=0, and ex_rt equals id rs, or equals id rt when the ID instruction is R-type, SW, BEQ or BNE.
  - Response, same cycle: pc_write=0, ifid_write=0, ID/EX <- bubble (all zero). stall_cnt+1.
- Branch resolved in EX:
  - Taken when (BEQ & ex_zero) or (BNE & !ex_zero).
  - Response: pc_sel=1, ifid_flush=1, ID/EX <- bubble. Two wrong-path instructions are killed. flush_cnt+1.
- Jump in ID, id_valid=1: pc_sel=2, ifid_flush=1, one bubble; ID/EX receives the J as a NOP. flush_cnt+1.
- Priority: taken branch > load-use stall > jump.
  - Taken branch with stall or jump in the same cycle: stall and jump are ignored (wrong path); pc_write=1.
  - Stall together with a jump in ID: the jump is not a stall consumer; a jump never stalls.
- Default outputs: pc_write=1, ifid_write=1, ifid_flush=0, pc_sel=0.
- Counters hold at all ones (no wrap).

Optional Feature:
PIPE_CTRL_IMM_EN
- Defined: decodes ADDI (001000, ADD), ANDI (001100, AND), ORI (001101, OR), SLTI (001010, SLT), each with ALUsrc=1, RegWrite=1, RegDst=0. For hazard detection these use rs only.
- Undefined: these opcodes are illegal NOPs.

Decomposition:
- Package pipe_ctrl_pkg: opcode and funct constants, ALUop encodings, ALU_NOP, packed structs for the ex/m/wb bundles, pc_sel enum.
- One sub-module: pipe_ctrl_decode, the pure combinational decoder. The top holds the stage registers, hazard logic and counters.

Test Plan:
1. Reset: rst_n=0 mid-stream -> all ctrl outputs 0 immediately; counters 0.
2. ADD followed by LW: ex_ctrl=1_0_00001 then 0_1_00001. After 3 cycles, wb_wb_ctrl for the LW = 2'b11.
3. LW $2 in EX, ID = ADD $3,$2,$4 -> one cycle pc_write=0, ifid_write=0, ex_ctrl=0; stall_cnt=1. LW with rt=$0 -> no stall.
4. BEQ in EX with ex_zero=1 and J in ID -> pc_sel=1, ifid_flush=1, J ignored, flush_cnt=1. BNE with ex_zero=1 -> pc_sel=0.
5. J 0x0000010 with id_pc4=0x40000004 -> jump_target=0x40000040, pc_sel=2, one bubble.
6. Funct 000111 -> illegal=1, ALUop=11111, RegWrite=0; with PIPE_CTRL_IMM_EN, ADDI -> ex_ctrl=0_1_00001, illegal=0.
